// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: assembles 11-bit frames into scan codes.
// Absorbs E0/F0 prefixes as flags and flags framing or timeout errors.
module ps2_frame_rx #(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int TO_W           = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_db,
  input  logic       ps2_data_db,
  output logic [7:0] scan_code,
  output logic       is_break,
  output logic       is_extended,
  output logic       code_valid,
  output logic       frame_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]      state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            par_q, par_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            ext_pend_q, ext_pend_d;
  logic            brk_pend_q, brk_pend_d;
  logic            clk_prev_q;
  logic [7:0]      scan_code_q, scan_code_d;
  logic            is_break_q, is_break_d;
  logic            is_ext_q, is_ext_d;
  logic            code_valid_q, code_valid_d;
  logic            frame_err_q, frame_err_d;

  logic fall;
  logic good;

  assign fall = clk_prev_q & ~ps2_clk_db;
  assign good = ps2_data_db & (^shreg_q ^ par_q);

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    par_d        = par_q;
    to_cnt_d     = '0;
    ext_pend_d   = ext_pend_q;
    brk_pend_d   = brk_pend_q;
    scan_code_d  = scan_code_q;
    is_break_d   = is_break_q;
    is_ext_d     = is_ext_q;
    code_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    if (state_q != IDLE && !fall) begin
      if (to_cnt_q == TO_LAST) begin
        state_d     = IDLE;
        frame_err_d = 1'b1;
        ext_pend_d  = 1'b0;
        brk_pend_d  = 1'b0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end

    if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!ps2_data_db) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            frame_err_d = 1'b1;
            ext_pend_d  = 1'b0;
            brk_pend_d  = 1'b0;
          end
        end
        DATA: begin
          // LSB arrives first, so shift in from the top
          shreg_d   = {ps2_data_db, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = ps2_data_db;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!good) begin
            frame_err_d = 1'b1;
            ext_pend_d  = 1'b0;
            brk_pend_d  = 1'b0;
          end else if (shreg_q == 8'hE0) begin
            ext_pend_d = 1'b1;
          end else if (shreg_q == 8'hF0) begin
            brk_pend_d = 1'b1;
          end else begin
            scan_code_d  = shreg_q;
            is_ext_d     = ext_pend_q;
            is_break_d   = brk_pend_q;
            code_valid_d = 1'b1;
            ext_pend_d   = 1'b0;
            brk_pend_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      ext_pend_q   <= 1'b0;
      brk_pend_q   <= 1'b0;
      clk_prev_q   <= 1'b1;
      scan_code_q  <= '0;
      is_break_q   <= 1'b0;
      is_ext_q     <= 1'b0;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      to_cnt_q     <= to_cnt_d;
      ext_pend_q   <= ext_pend_d;
      brk_pend_q   <= brk_pend_d;
      clk_prev_q   <= ps2_clk_db;
      scan_code_q  <= scan_code_d;
      is_break_q   <= is_break_d;
      is_ext_q     <= is_ext_d;
      code_valid_q <= code_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign scan_code   = scan_code_q;
  assign is_break    = is_break_q;
  assign is_extended = is_ext_q;
  assign code_valid  = code_valid_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx.
// Drives PS/2 frames bit by bit and checks codes, flags and errors.
module tb_ps2_frame_rx;

  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk_db = 1'b1;
  logic       ps2_data_db = 1'b1;
  logic [7:0] scan_code;
  logic       is_break;
  logic       is_extended;
  logic       code_valid;
  logic       frame_err;

  int pass_cnt = 0;
  int total = 0;
  int nvalid = 0;
  int nerr = 0;
  int nboth = 0;
  logic [7:0] last_code = 8'h00;
  logic       last_brk = 1'b0;
  logic       last_ext = 1'b0;

  ps2_frame_rx #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ps2_clk_db(ps2_clk_db),
    .ps2_data_db(ps2_data_db),
    .scan_code(scan_code),
    .is_break(is_break),
    .is_extended(is_extended),
    .code_valid(code_valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (code_valid) begin
      nvalid++;
      last_code = scan_code;
      last_brk = is_break;
      last_ext = is_extended;
    end
    if (frame_err) nerr++;
    if (code_valid && frame_err) nboth++;
  end

  task automatic send_bit(input logic b);
    @(posedge clk); #1 ps2_data_db = b;
    repeat (2) @(posedge clk);
    #1 ps2_clk_db = 1'b0;
    repeat (4) @(posedge clk);
    #1 ps2_clk_db = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p,
                            input logic stp);
    logic [7:0] v;
    v = b;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
    send_bit(p);
    send_bit(stp);
    #1 ps2_data_db = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (scan_code !== 8'h00)
      $display("FAIL reset_code got=%h exp=00", scan_code);
    else pass_cnt++;
    total++; if (is_break !== 1'b0 || is_extended !== 1'b0)
      $display("FAIL reset_flags got=%b%b exp=00", is_break, is_extended);
    else pass_cnt++;
    total++; if (code_valid !== 1'b0 || frame_err !== 1'b0)
      $display("FAIL reset_pulses got=%b%b exp=00", code_valid, frame_err);
    else pass_cnt++;
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_make;
    int v0, e0;
    logic [7:0] v;
    v = 8'h1C;
    v0 = nvalid; e0 = nerr;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
    send_bit(1'b0);
    @(posedge clk); #1 ps2_data_db = 1'b1;
    repeat (2) @(posedge clk);
    #1 ps2_clk_db = 1'b0;
    @(negedge clk);
    total++; if (code_valid !== 1'b0)
      $display("FAIL make_early got=%b exp=0", code_valid);
    else pass_cnt++;
    @(negedge clk);
    total++; if (code_valid !== 1'b1)
      $display("FAIL make_latency got=%b exp=1", code_valid);
    else pass_cnt++;
    total++; if (scan_code !== 8'h1C || is_break !== 1'b0
                 || is_extended !== 1'b0)
      $display("FAIL make_code got=%h/%b/%b exp=1c/0/0",
               scan_code, is_break, is_extended);
    else pass_cnt++;
    @(negedge clk);
    total++; if (code_valid !== 1'b0)
      $display("FAIL make_width got=%b exp=0", code_valid);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1 ps2_clk_db = 1'b1;
    repeat (4) @(posedge clk);
    total++; if (nvalid - v0 !== 1 || nerr - e0 !== 0)
      $display("FAIL make_counts got=v%0d e%0d exp=v1 e0",
               nvalid - v0, nerr - e0);
    else pass_cnt++;
  endtask

  task automatic test_break;
    int v0;
    v0 = nvalid;
    send_frame(8'hF0, 1'b1, 1'b1);
    total++; if (nvalid - v0 !== 0)
      $display("FAIL brk_prefix got=%0d exp=0", nvalid - v0);
    else pass_cnt++;
    send_frame(8'h1C, 1'b0, 1'b1);
    total++; if (nvalid - v0 !== 1 || last_code !== 8'h1C
                 || last_brk !== 1'b1 || last_ext !== 1'b0)
      $display("FAIL brk_code got=%0d/%h/%b/%b exp=1/1c/1/0",
               nvalid - v0, last_code, last_brk, last_ext);
    else pass_cnt++;
  endtask

  task automatic test_ext_break;
    int v0;
    v0 = nvalid;
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    total++; if (nvalid - v0 !== 1 || last_code !== 8'h75
                 || last_brk !== 1'b1 || last_ext !== 1'b1)
      $display("FAIL extbrk_code got=%0d/%h/%b/%b exp=1/75/1/1",
               nvalid - v0, last_code, last_brk, last_ext);
    else pass_cnt++;
    send_frame(8'h1C, 1'b0, 1'b1);
    total++; if (nvalid - v0 !== 2 || last_code !== 8'h1C
                 || last_brk !== 1'b0 || last_ext !== 1'b0)
      $display("FAIL extbrk_clear got=%0d/%h/%b/%b exp=2/1c/0/0",
               nvalid - v0, last_code, last_brk, last_ext);
    else pass_cnt++;
  endtask

  task automatic test_parity;
    int v0, e0;
    v0 = nvalid; e0 = nerr;
    send_frame(8'h75, 1'b1, 1'b1);
    total++; if (nerr - e0 !== 1 || nvalid - v0 !== 0)
      $display("FAIL par_err got=e%0d v%0d exp=e1 v0",
               nerr - e0, nvalid - v0);
    else pass_cnt++;
    total++; if (scan_code !== 8'h1C)
      $display("FAIL par_hold got=%h exp=1c", scan_code);
    else pass_cnt++;
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    total++; if (nvalid - v0 !== 1 || nerr - e0 !== 2
                 || last_code !== 8'h1C || last_ext !== 1'b0)
      $display("FAIL par_recover got=v%0d e%0d %h/%b exp=v1 e2 1c/0",
               nvalid - v0, nerr - e0, last_code, last_ext);
    else pass_cnt++;
  endtask

  task automatic test_stop_start;
    int v0, e0;
    v0 = nvalid; e0 = nerr;
    send_frame(8'h1C, 1'b0, 1'b0);
    total++; if (nerr - e0 !== 1 || nvalid - v0 !== 0)
      $display("FAIL stop_err got=e%0d v%0d exp=e1 v0",
               nerr - e0, nvalid - v0);
    else pass_cnt++;
    send_bit(1'b1);
    total++; if (nerr - e0 !== 2)
      $display("FAIL bad_start got=%0d exp=2", nerr - e0);
    else pass_cnt++;
  endtask

  task automatic test_timeout;
    int v0, e0;
    send_frame(8'hE0, 1'b0, 1'b1);
    v0 = nvalid; e0 = nerr;
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    repeat (TO - 20) @(posedge clk);
    total++; if (nerr - e0 !== 0)
      $display("FAIL to_early got=%0d exp=0", nerr - e0);
    else pass_cnt++;
    repeat (30) @(posedge clk);
    total++; if (nerr - e0 !== 1)
      $display("FAIL to_err got=%0d exp=1", nerr - e0);
    else pass_cnt++;
    send_frame(8'h1C, 1'b0, 1'b1);
    total++; if (nvalid - v0 !== 1 || last_code !== 8'h1C
                 || last_ext !== 1'b0)
      $display("FAIL to_recover got=%0d/%h/%b exp=1/1c/0",
               nvalid - v0, last_code, last_ext);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int v0;
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    total++; if (scan_code !== 8'h00 || code_valid !== 1'b0
                 || frame_err !== 1'b0)
      $display("FAIL rstmid_out got=%h/%b/%b exp=00/0/0",
               scan_code, code_valid, frame_err);
    else pass_cnt++;
    ps2_data_db = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    v0 = nvalid;
    send_frame(8'h1C, 1'b0, 1'b1);
    total++; if (nvalid - v0 !== 1 || last_code !== 8'h1C
                 || last_ext !== 1'b0 || last_brk !== 1'b0)
      $display("FAIL rstmid_code got=%0d/%h/%b/%b exp=1/1c/0/0",
               nvalid - v0, last_code, last_ext, last_brk);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int v0, e0;
    v0 = nvalid; e0 = nerr;
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    total++; if (nvalid - v0 !== 2 || nerr - e0 !== 0
                 || last_code !== 8'h75)
      $display("FAIL b2b got=v%0d e%0d %h exp=v2 e0 75",
               nvalid - v0, nerr - e0, last_code);
    else pass_cnt++;
    total++; if (nboth !== 0)
      $display("FAIL overlap got=%0d exp=0", nboth);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_ext_break();
    test_parity();
    test_stop_start();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
